// File: rtl/index_reader_if.sv
// Bundle of the burst-control, SRAM read-port and index-stream signals of index_reader.
// The master modport is the reader itself; the slave modport is its environment.
interface index_reader_if #(
  parameter int RD_DATA_WIDTH = 4,
  parameter int RD_DATA_DEPTH = 65536,
  parameter int IDX_WIDTH     = 2
);
  localparam int RD_ADDR_WIDTH = $clog2(RD_DATA_DEPTH);

  logic                     start;
  logic [RD_ADDR_WIDTH-1:0] base_addr;
  logic [RD_ADDR_WIDTH:0]   num_words;
  logic                     busy;
  logic                     done;
  logic                     sram_rd;
  logic [RD_ADDR_WIDTH-1:0] sram_rd_addr;
  logic [RD_DATA_WIDTH-1:0] sram_data_out;
  logic                     idx_valid;
  logic                     idx_ready;
  logic [IDX_WIDTH-1:0]     idx_data;
  logic                     idx_last;

  modport master (
    input  start, base_addr, num_words, sram_data_out, idx_ready,
    output busy, done, sram_rd, sram_rd_addr, idx_valid, idx_data, idx_last
  );

  modport slave (
    output start, base_addr, num_words, sram_data_out, idx_ready,
    input  busy, done, sram_rd, sram_rd_addr, idx_valid, idx_data, idx_last
  );
endinterface

// File: rtl/index_reader.sv
// Reads a burst of packed pooling-index words from SRAM and streams the indices
// out one lane at a time, MSB lane first, with valid/ready backpressure.
module index_reader #(
  parameter int RD_DATA_WIDTH = 4,
  parameter int RD_DATA_DEPTH = 65536,
  parameter int IDX_WIDTH     = 2
) (
  input  logic          clk,
  input  logic          rst,
  index_reader_if.master bus
);
  localparam int RD_ADDR_WIDTH = $clog2(RD_DATA_DEPTH);
  localparam int LANES         = RD_DATA_WIDTH / IDX_WIDTH;
  localparam int LANE_WIDTH    = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] OUT  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [RD_ADDR_WIDTH-1:0] LAST_ADDR = RD_ADDR_WIDTH'(RD_DATA_DEPTH - 1);
  localparam logic [RD_ADDR_WIDTH-1:0] ADDR_ONE  = RD_ADDR_WIDTH'(1);
  localparam logic [RD_ADDR_WIDTH:0]   REM_ONE   = (RD_ADDR_WIDTH + 1)'(1);
  localparam logic [LANE_WIDTH-1:0]    LAST_LANE = LANE_WIDTH'(LANES - 1);
  localparam logic [LANE_WIDTH-1:0]    LANE_ONE  = LANE_WIDTH'(1);

  logic [2:0]               state_reg, state_next;
  logic [RD_ADDR_WIDTH-1:0] cur_addr_reg;
  logic [RD_ADDR_WIDTH-1:0] cur_addr_next;
  logic [RD_ADDR_WIDTH:0]   remaining_reg;
  logic [LANE_WIDTH-1:0]    lane_reg;
  logic [RD_DATA_WIDTH-1:0] shift_reg;
  logic                     sram_rd_reg;
  logic [RD_ADDR_WIDTH-1:0] sram_rd_addr_reg;
  logic                     transfer;
  logic                     last_lane;

  assign transfer  = (state_reg == OUT) && bus.idx_ready;
  assign last_lane = (lane_reg == LAST_LANE);

  // Explicit wrap so a non-power-of-two depth still cycles through 0..DEPTH-1
  assign cur_addr_next = (cur_addr_reg == LAST_ADDR) ? '0 : cur_addr_reg + ADDR_ONE;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.num_words == '0) ? DONE : RD;
        end
      end
      RD:   state_next = LOAD;
      LOAD: state_next = OUT;
      OUT: begin
        if (transfer && last_lane) begin
          state_next = (remaining_reg == '0) ? DONE : RD;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      cur_addr_reg     <= '0;
      remaining_reg    <= '0;
      lane_reg         <= '0;
      shift_reg        <= '0;
      sram_rd_reg      <= 1'b0;
      sram_rd_addr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      sram_rd_reg <= (state_next == RD);
      // The read address is registered alongside the enable; entering RD from
      // IDLE the word address is the one being captured this very edge.
      if (state_next == RD) begin
        sram_rd_addr_reg <= (state_reg == IDLE) ? bus.base_addr : cur_addr_reg;
      end
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cur_addr_reg  <= bus.base_addr;
            remaining_reg <= bus.num_words;
          end
        end
        RD: begin
          cur_addr_reg  <= cur_addr_next;
          remaining_reg <= remaining_reg - REM_ONE;
        end
        LOAD: begin
          shift_reg <= bus.sram_data_out;
          lane_reg  <= '0;
        end
        OUT: begin
          // Shifting keeps the current lane in the top bits, matching a lane-indexed select
          if (transfer && !last_lane) begin
            lane_reg  <= lane_reg + LANE_ONE;
            shift_reg <= shift_reg << IDX_WIDTH;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state_reg != IDLE);
  assign bus.done         = (state_reg == DONE);
  assign bus.sram_rd      = sram_rd_reg;
  assign bus.sram_rd_addr = sram_rd_addr_reg;
  assign bus.idx_valid    = (state_reg == OUT);
  assign bus.idx_data     = shift_reg[RD_DATA_WIDTH-1 -: IDX_WIDTH];
  assign bus.idx_last     = (state_reg == OUT) && last_lane && (remaining_reg == '0);
endmodule
